// File: rtl/gin_ifmap_scheduler_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for the GIN ifmap scheduler.
package gin_sched_pkg;

   localparam int XBUS_NUMS   = 12;
   localparam int PE_NUMS     = 14;
   localparam int ID_LEN      = 5;
   localparam int ROW_LEN     = 4;
   localparam int VALUE_LEN   = 8;
   localparam int CFG_LEN     = 8;
   localparam int IFMAP_H     = 60;
   localparam int IFMAP_W     = 224;
   localparam int TAG_ROWS    = 30;
   localparam int ADDR_LEN    = 14;

   localparam int CFG_CNT_LEN = 8;
   localparam int COL_CNT_LEN = 8;
   localparam int ROW_CNT_LEN = 6;

   typedef enum logic [2:0] {
      IDLE,
      CFG_ROW,
      CFG_ID,
      STREAM,
      FINISH
   } sched_state_e;

   typedef struct packed {
      logic [ROW_LEN-1:0]   row_tag;
      logic [ID_LEN-1:0]    col_tag;
      logic [VALUE_LEN-1:0] value;
   } fifo_entry_t;

endpackage

// File: rtl/gin_ifmap_scheduler_if.sv
// Controller, config, GLB read and GIN handshake signals of the scheduler; master = scheduler side.
interface gin_ifmap_scheduler_if;
   import gin_sched_pkg::*;

   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CFG_LEN-1:0]   cfg_data;
   logic                 set_row;
   logic [ROW_LEN-1:0]   row_scan_out;
   logic                 set_id;
   logic [ID_LEN-1:0]    id_scan_out;
   logic                 glb_rd_en;
   logic [ADDR_LEN-1:0]  glb_rd_addr;
   logic [VALUE_LEN-1:0] glb_rd_data;
   logic                 gin_enable;
   logic                 gin_ready;
   logic [ROW_LEN-1:0]   gin_row_tag;
   logic [ID_LEN-1:0]    gin_col_tag;
   logic [VALUE_LEN-1:0] gin_value;

   modport master (
      input  start, cfg_valid, cfg_data, glb_rd_data, gin_ready,
      output busy, done, cfg_ready, set_row, row_scan_out, set_id, id_scan_out,
             glb_rd_en, glb_rd_addr, gin_enable, gin_row_tag, gin_col_tag, gin_value
   );

   modport slave (
      output start, cfg_valid, cfg_data, glb_rd_data, gin_ready,
      input  busy, done, cfg_ready, set_row, row_scan_out, set_id, id_scan_out,
             glb_rd_en, glb_rd_addr, gin_enable, gin_row_tag, gin_col_tag, gin_value
   );

endinterface

// File: rtl/gin_sched_fifo2.sv
// Two-entry FIFO holding GLB read data with its tags until the GIN accepts it.
module gin_sched_fifo2
   import gin_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  fifo_entry_t din,
   output fifo_entry_t head,
   output logic [1:0]  count
);

   fifo_entry_t mem_q [2];
   fifo_entry_t mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/gin_ifmap_scheduler.sv
// Shifts the GIN row/ID scan chains from a config stream, then multicasts the ifmap column-major.
//   state   | meaning
//   IDLE    | waiting for start
//   CFG_ROW | shifting XBUS_NUMS row-tag words into the row scan chain
//   CFG_ID  | shifting XBUS_NUMS*PE_NUMS col-ID words into the ID scan chain
//   STREAM  | reading GLB column-major and feeding the GIN through the FIFO
//   FINISH  | one-cycle done pulse
module gin_ifmap_scheduler
   import gin_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   gin_ifmap_scheduler_if.master bus
);

   localparam logic [ADDR_LEN-1:0] TOTAL = ADDR_LEN'(IFMAP_H * IFMAP_W);

   sched_state_e            state_q, state_d;
   logic [CFG_CNT_LEN-1:0]  cfg_cnt_q, cfg_cnt_d;
   logic [COL_CNT_LEN-1:0]  c_q, c_d;
   logic [ROW_CNT_LEN-1:0]  r_q, r_d;
   logic [ADDR_LEN-1:0]     addr_q, addr_d;
   logic [ADDR_LEN-1:0]     remain_q, remain_d;
   logic [ROW_LEN-1:0]      tag_row_q, tag_row_d, rd_row_q, rd_row_d;
   logic [ID_LEN-1:0]       tag_col_q, tag_col_d, rd_col_q, rd_col_d;
   logic                    inflight_q, inflight_d;

   logic        cfg_ready, cfg_acc, rd_en, pop;
   logic [1:0]  fifo_count;
   logic [2:0]  occ;
   fifo_entry_t push_entry, head;

   assign cfg_ready  = (state_q == CFG_ROW) || (state_q == CFG_ID);
   assign cfg_acc    = bus.cfg_valid & cfg_ready;
   assign pop        = (fifo_count != 2'd0) & bus.gin_ready;
   assign push_entry = '{row_tag: rd_row_q, col_tag: rd_col_q, value: bus.glb_rd_data};

   // A transfer in this cycle frees its slot, which keeps the read pipe full under continuous ready.
   assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
   assign rd_en = (state_q == STREAM) && (remain_q != '0) && (occ < 3'd2);

   always_comb begin
      state_d    = state_q;
      cfg_cnt_d  = cfg_cnt_q;
      c_d        = c_q;
      r_d        = r_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      tag_row_d  = tag_row_q;
      tag_col_d  = tag_col_q;
      inflight_d = rd_en;
      rd_row_d   = rd_en ? tag_row_q : rd_row_q;
      rd_col_d   = rd_en ? tag_col_q : rd_col_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CFG_ROW;
               cfg_cnt_d = CFG_CNT_LEN'(XBUS_NUMS - 1);
               c_d       = '0;
               r_d       = '0;
               addr_d    = '0;
               remain_d  = TOTAL;
               tag_row_d = '0;
               tag_col_d = '0;
            end
         end
         CFG_ROW: begin
            if (cfg_acc) begin
               if (cfg_cnt_q == '0) begin
                  state_d   = CFG_ID;
                  cfg_cnt_d = CFG_CNT_LEN'(XBUS_NUMS * PE_NUMS - 1);
               end else begin
                  cfg_cnt_d = cfg_cnt_q - 1'b1;
               end
            end
         end
         CFG_ID: begin
            if (cfg_acc) begin
               if (cfg_cnt_q == '0) state_d = STREAM;
               else                 cfg_cnt_d = cfg_cnt_q - 1'b1;
            end
         end
         STREAM: begin
            if (rd_en) begin
               remain_d = remain_q - 1'b1;
               if (r_q == ROW_CNT_LEN'(IFMAP_H - 1)) begin
                  r_d       = '0;
                  c_d       = c_q + 1'b1;
                  addr_d    = ADDR_LEN'(c_q) + ADDR_LEN'(1);
                  tag_row_d = '0;
                  tag_col_d = '0;
               end else begin
                  r_d    = r_q + 1'b1;
                  addr_d = addr_q + ADDR_LEN'(IFMAP_W);
                  if (tag_col_q == ID_LEN'(TAG_ROWS - 1)) begin
                     tag_col_d = '0;
                     tag_row_d = tag_row_q + 1'b1;
                  end else begin
                     tag_col_d = tag_col_q + 1'b1;
                  end
               end
            end
            if ((remain_q == '0) && !inflight_q && (fifo_count == 2'd0)) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cfg_cnt_q  <= '0;
         c_q        <= '0;
         r_q        <= '0;
         addr_q     <= '0;
         remain_q   <= '0;
         tag_row_q  <= '0;
         tag_col_q  <= '0;
         rd_row_q   <= '0;
         rd_col_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_cnt_q  <= cfg_cnt_d;
         c_q        <= c_d;
         r_q        <= r_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         tag_row_q  <= tag_row_d;
         tag_col_q  <= tag_col_d;
         rd_row_q   <= rd_row_d;
         rd_col_q   <= rd_col_d;
         inflight_q <= inflight_d;
      end
   end

   gin_sched_fifo2 u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (inflight_q),
      .pop   (pop),
      .din   (push_entry),
      .head  (head),
      .count (fifo_count)
   );

   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = (state_q == FINISH);
   assign bus.cfg_ready    = cfg_ready;
   assign bus.set_row      = cfg_acc && (state_q == CFG_ROW);
   assign bus.row_scan_out = (state_q == CFG_ROW) ? bus.cfg_data[ROW_LEN-1:0] : '0;
   assign bus.set_id       = cfg_acc && (state_q == CFG_ID);
   assign bus.id_scan_out  = (state_q == CFG_ID) ? bus.cfg_data[ID_LEN-1:0] : '0;
   assign bus.glb_rd_en    = rd_en;
   assign bus.glb_rd_addr  = addr_q;
   assign bus.gin_enable   = (fifo_count != 2'd0);
   assign bus.gin_row_tag  = head.row_tag;
   assign bus.gin_col_tag  = head.col_tag;
   assign bus.gin_value    = head.value;

endmodule

// File: tb/tb_gin_ifmap_scheduler.sv
// Directed bench for gin_ifmap_scheduler: config scan, column-major stream, stalls, mid-pass reset.
module tb_gin_ifmap_scheduler;
   import gin_sched_pkg::*;

   localparam int TOTAL  = IFMAP_H * IFMAP_W;
   localparam int N_ROWW = XBUS_NUMS;
   localparam int N_IDW  = XBUS_NUMS * PE_NUMS;

   logic clk = 1'b0;
   logic rst = 1'b0;

   gin_ifmap_scheduler_if bus();

   gin_ifmap_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // GLB model: mem[a] = a[7:0], one-cycle read latency
   always @(posedge clk or negedge rst) begin
      if (!rst)               bus.glb_rd_data <= '0;
      else if (bus.glb_rd_en) bus.glb_rd_data <= bus.glb_rd_addr[7:0];
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_addr(input int idx);
      return (idx % IFMAP_H) * IFMAP_W + (idx / IFMAP_H);
   endfunction

   // monitor state
   int cyc, n_row, n_id, id_bad, issued, xfers, first_rd, first_en, t_last_id;
   int t_first_x, t_last_x, elem_bad, addr_bad, occ_bad, stall_bad, n_done;
   int addr30, addr_last;
   int row_vals [12];
   int cap_row [5];
   int cap_col [5];
   int cap_val [5];
   bit stall_prev;
   logic [16:0] head_prev;

   task automatic reset_stats();
      cyc = 0; n_row = 0; n_id = 0; id_bad = 0; issued = 0; xfers = 0;
      first_rd = -1; first_en = -1; t_last_id = -1; t_first_x = -1; t_last_x = -1;
      elem_bad = 0; addr_bad = 0; occ_bad = 0; stall_bad = 0; n_done = 0;
      addr30 = -1; addr_last = -1; stall_prev = 0; head_prev = '0;
      for (int i = 0; i < 12; i++) row_vals[i] = -1;
      for (int i = 0; i < 5; i++) begin cap_row[i] = -1; cap_col[i] = -1; cap_val[i] = -1; end
   endtask

   initial begin
      logic [16:0] head_now;
      bit pop_m;
      int s, r;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc++;
            if (bus.set_row) begin
               if (n_row < 12) row_vals[n_row] = int'(bus.row_scan_out);
               n_row++;
            end
            if (bus.set_id) begin
               if (!bus.cfg_valid || int'(bus.id_scan_out) != (n_id % 32)) id_bad++;
               n_id++;
               if (n_id == N_IDW) t_last_id = cyc;
            end
            pop_m = bus.gin_enable & bus.gin_ready;
            if (bus.glb_rd_en) begin
               if (first_rd < 0) first_rd = cyc;
               if (issued - xfers - int'(pop_m) >= 2) occ_bad++;
               if (int'(bus.glb_rd_addr) != exp_addr(issued)) addr_bad++;
               if (issued == 30) addr30 = int'(bus.glb_rd_addr);
               if (issued == TOTAL - 1) addr_last = int'(bus.glb_rd_addr);
               issued++;
            end
            if (bus.gin_enable && first_en < 0) first_en = cyc;
            head_now = {bus.gin_row_tag, bus.gin_col_tag, bus.gin_value};
            if (stall_prev && (!bus.gin_enable || head_now != head_prev)) stall_bad++;
            stall_prev = bus.gin_enable && !bus.gin_ready;
            head_prev  = head_now;
            if (pop_m) begin
               r = xfers % IFMAP_H;
               if (int'(bus.gin_row_tag) != r / TAG_ROWS || int'(bus.gin_col_tag) != r % TAG_ROWS ||
                   int'(bus.gin_value) != exp_addr(xfers) % 256) elem_bad++;
               s = (xfers < 3) ? xfers : (xfers == 30) ? 3 : (xfers == TOTAL - 1) ? 4 : -1;
               if (s >= 0) begin
                  cap_row[s] = int'(bus.gin_row_tag);
                  cap_col[s] = int'(bus.gin_col_tag);
                  cap_val[s] = int'(bus.gin_value);
               end
               if (t_first_x < 0) t_first_x = cyc;
               t_last_x = cyc;
               xfers++;
            end
            if (bus.done) n_done++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_cfg(input bit toggle);
      int k = 0;
      int guard = 0;
      bit phase = 1'b1;
      bit acc;
      while (k < N_ROWW + N_IDW && guard < 2000) begin
         bus.cfg_valid = toggle ? phase : 1'b1;
         phase = ~phase;
         bus.cfg_data = (k < N_ROWW) ? 8'(k) : 8'(k - N_ROWW);
         @(negedge clk);
         acc = bus.cfg_valid & bus.cfg_ready;
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 8'h5A;
      chk("cfg_words_accepted", k, N_ROWW + N_IDW);
   endtask

   task automatic run_stream(input int mode);
      int i = 0;
      while (n_done == 0 && i < 40000) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (mode == 1) begin
            bus.gin_ready = (i >= 300 && i < 310) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == 1000) bus.start = 1'b1;
         end else begin
            bus.gin_ready = 1'b1;
         end
         i++;
      end
      chk("done_seen", n_done, 1);
      @(negedge clk);
      chk("busy_after_done", int'(bus.busy), 0);
      chk("done_one_cycle", n_done, 1);
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_busy"}, int'(bus.busy), 0);
      chk({pfx, "_done"}, int'(bus.done), 0);
      chk({pfx, "_cfg_ready"}, int'(bus.cfg_ready), 0);
      chk({pfx, "_set_row"}, int'(bus.set_row), 0);
      chk({pfx, "_set_id"}, int'(bus.set_id), 0);
      chk({pfx, "_row_scan"}, int'(bus.row_scan_out), 0);
      chk({pfx, "_id_scan"}, int'(bus.id_scan_out), 0);
      chk({pfx, "_rd_en"}, int'(bus.glb_rd_en), 0);
      chk({pfx, "_rd_addr"}, int'(bus.glb_rd_addr), 0);
      chk({pfx, "_gin_en"}, int'(bus.gin_enable), 0);
      chk({pfx, "_row_tag"}, int'(bus.gin_row_tag), 0);
      chk({pfx, "_col_tag"}, int'(bus.gin_col_tag), 0);
      chk({pfx, "_value"}, int'(bus.gin_value), 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 8'h5A;
      bus.gin_ready = 1'b0;
      reset_stats();
      #1;
      chk_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // pass 1: cfg_valid held, gin_ready tied high
      pulse_start();
      chk("busy_after_start", int'(bus.busy), 1);
      run_cfg(1'b0);
      run_stream(0);
      chk("p1_row_count", n_row, N_ROWW);
      for (int i = 0; i < 12; i++) chk($sformatf("p1_row_scan%0d", i), row_vals[i], i);
      chk("p1_id_count", n_id, N_IDW);
      chk("p1_id_bad", id_bad, 0);
      chk("p1_first_rd_lat", first_rd - t_last_id, 1);
      chk("p1_first_en_lat", first_en - t_last_id, 3);
      chk("p1_xfers", xfers, TOTAL);
      chk("p1_span", t_last_x - t_first_x + 1, TOTAL);
      chk("p1_elem_bad", elem_bad, 0);
      chk("p1_addr_bad", addr_bad, 0);
      chk("p1_x0", cap_row[0] * 1000 + cap_col[0] * 256 + cap_val[0], 0);
      chk("p1_x1_col", cap_col[1], 1);
      chk("p1_x1_val", cap_val[1], 'hE0);
      chk("p1_x2_col", cap_col[2], 2);
      chk("p1_x2_val", cap_val[2], 'hC0);
      chk("p1_x30_row", cap_row[3], 1);
      chk("p1_x30_col", cap_col[3], 0);
      chk("p1_addr30", addr30, 6720);
      chk("p1_last_row", cap_row[4], 1);
      chk("p1_last_col", cap_col[4], 29);
      chk("p1_addr_last", addr_last, 13439);

      // pass 2: toggling cfg_valid, random ready with a 10-cycle stall, stray start
      reset_stats();
      bus.gin_ready = 1'b0;
      pulse_start();
      run_cfg(1'b1);
      run_stream(1);
      chk("p2_row_count", n_row, N_ROWW);
      chk("p2_id_count", n_id, N_IDW);
      chk("p2_id_bad", id_bad, 0);
      chk("p2_xfers", xfers, TOTAL);
      chk("p2_issued", issued, TOTAL);
      chk("p2_elem_bad", elem_bad, 0);
      chk("p2_addr_bad", addr_bad, 0);
      chk("p2_stall_bad", stall_bad, 0);
      chk("p2_occ_bad", occ_bad, 0);

      // pass 3: reset asserted mid-stream
      reset_stats();
      pulse_start();
      run_cfg(1'b0);
      bus.gin_ready = 1'b1;
      repeat (100) @(posedge clk);
      chk("p3_mid_progress", int'(xfers > 50 && bus.busy), 1);
      #3 rst = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      reset_stats();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // pass 4: full pass after reset release
      pulse_start();
      run_cfg(1'b0);
      run_stream(0);
      chk("p4_row_count", n_row, N_ROWW);
      chk("p4_id_count", n_id, N_IDW);
      chk("p4_xfers", xfers, TOTAL);
      chk("p4_elem_bad", elem_bad, 0);
      chk("p4_first_val", cap_val[0], 0);
      chk("p4_span", t_last_x - t_first_x + 1, TOTAL);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/gin_ifmap_scheduler.md
Name: gin_ifmap_scheduler

Overview:
- Sequences one ifmap pass through the Global Input Network (GIN).
- After a start pulse it shifts the row-tag and PE-ID scan chains from a config word stream.
- It then reads the ifmap out of the GLB column-major and multicasts each element to the GIN with computed row/col tags, using the GIN enable/ready handshake.
- Sits between the top-level controller / GLB and the GIN instance of the PE array.

Parameters:
- XBUS_NUMS, 12, number of X-buses (rows of PEs)
- PE_NUMS, 14, PEs per X-bus
- ID_LEN, 5, PE col-ID width
- ROW_LEN, 4, X-bus row-tag width
- VALUE_LEN, 8, ifmap element width
- CFG_LEN, 8, config word width; low ROW_LEN/ID_LEN bits used
- IFMAP_H, 60, ifmap rows per pass
- IFMAP_W, 224, ifmap columns per pass
- TAG_ROWS, 30, ifmap rows per row_tag group
- ADDR_LEN, 14, GLB word address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin config+stream pass
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last GIN transfer
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config word accepted when valid&ready
- cfg_data  in  CFG_LEN  config word (row words first, then ID words)
- set_row  out  1  GIN row scan shift enable
- row_scan_out  out  ROW_LEN  row scan data to GIN row_scan_in
- set_id  out  1  GIN ID scan shift enable
- id_scan_out  out  ID_LEN  ID scan data to GIN id_scan_in
- glb_rd_en  out  1  GLB read request
- glb_rd_addr  out  ADDR_LEN  GLB read address
- glb_rd_data  in  VALUE_LEN  GLB read data, valid exactly 1 cycle after glb_rd_en
- gin_enable  out  1  GIN element valid
- gin_ready  in  1  GIN accepts element
- gin_row_tag  out  ROW_LEN  row tag
- gin_col_tag  out  ID_LEN  col tag
- gin_value  out  VALUE_LEN  ifmap value

Behaviour:
- Reset (rst=0, async): state IDLE; all counters and FIFO cleared. Outputs busy, done, cfg_ready, set_row, set_id, glb_rd_en and gin_enable are 0; every data/tag/address output is 0.
- FSM: IDLE -> CFG_ROW -> CFG_ID -> STREAM -> FINISH -> IDLE.
- IDLE: start=1 -> CFG_ROW, busy=1. start in any other state is ignored.
- CFG_ROW:
  - cfg_ready=1.
  - set_row = cfg_valid & cfg_ready, and row_scan_out = cfg_data[ROW_LEN-1:0], both combinational.
  - Exactly one scan shift per accepted word; cfg_valid low means no shift.
  - After XBUS_NUMS accepted words -> CFG_ID.
- CFG_ID: same as CFG_ROW on set_id/id_scan_out, for XBUS_NUMS*PE_NUMS words -> STREAM. cfg_ready=0 outside CFG states.
- STREAM order: outer c = 0..IFMAP_W-1, inner r = 0..IFMAP_H-1.
- Address: addr = r*IFMAP_W + c, generated without a multiplier. Add IFMAP_W per r step; at r wrap, reload with c+1.
- Tags:
  - row_tag = r/TAG_ROWS and col_tag = r%TAG_ROWS, from a wrap counter. col_tag wraps at TAG_ROWS-1 and increments row_tag.
  - Both reset to 0 at each new column.
- Read issue: glb_rd_en=1 when fifo_count + inflight < 2 and elements remain.
  - inflight is a 1-bit register tracking the previous cycle's glb_rd_en.
  - The tags are registered alongside the read, so they align with glb_rd_data in the following cycle.
  - That data+tags entry is pushed into the 2-entry FIFO.
- GIN side:
  - gin_enable = FIFO non-empty; tags and value are driven from the FIFO head.
  - A transfer occurs on the clk edge with gin_enable&gin_ready; the FIFO pops.
  - The head is stable while gin_enable=1 & gin_ready=0.
  - Sustained throughput is 1 element/cycle under continuous ready.
  - Push and pop in the same cycle keep the count unchanged. The FIFO never overflows, guaranteed by the issue rule.
- STREAM -> FINISH when all IFMAP_H*IFMAP_W reads are issued and the last element has transferred.
- FINISH: done=1 for one cycle, busy=0 next cycle -> IDLE.
- Latency: first gin_enable is 2 cycles after entry to STREAM.
- Reset mid-pass: immediate abort to IDLE; a partial scan chain is not restored (the controller must reconfigure).

Decomposition:
- Package gin_sched_pkg: state enum (IDLE, CFG_ROW, CFG_ID, STREAM, FINISH); default parameter constants; FIFO entry struct {row_tag, col_tag, value}.
- Sub-module gin_sched_fifo2: 2-entry FIFO with push, pop and count, async active-low reset.

Test Plan:
- Reset then start, cfg_valid held 1 with 12 row words 0x00..0x0B then 168 ID words -> set_row high exactly 12 cycles with row_scan_out 0..11; set_id high exactly 168 cycles.
- cfg_valid toggling 1/0 during CFG_ID -> set_id only in valid cycles; total set_id count remains 168.
- GLB preloaded with mem[a] = a[7:0], gin_ready tied 1 -> 13440 transfers, 1/cycle.
  - First three transfers: (row_tag 0, col_tag 0, value 0x00), (0, 1, 0xE0), (0, 2, 0xC0).
  - r=30 c=0: tag (1, 0), addr 6720.
  - Last: addr 13439, tag (1, 29); done pulses once, busy falls.
- gin_ready random 50%, then held 0 for 10 cycles -> gin_enable/tags/value stable while stalled; no element lost or duplicated; glb_rd_en stops once FIFO + inflight = 2.
- start pulsed during STREAM -> ignored, sequence unchanged.
- rst=0 asserted mid-STREAM -> all outputs 0 asynchronously. A new start after release performs a full config+stream pass from element 0.
